// File: rtl/data_mem_responder.sv
// Data-port memory responder: req/ready accept, programmable wait states, one-cycle response pulse.
// Optional DMEM_BYTE_WRITE_EN enables per-lane store masking with relaxed alignment checking.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Req,
    input  logic        i_WE,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WData,
    input  logic [3:0]  i_ByteEn,
    output logic        o_Ready,
    output logic        o_RValid,
    output logic [31:0] o_RData,
    output logic        o_Err,
    output logic        o_Busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_next;
    logic [3:0]    wait_cnt;
    logic          req_we;
    logic [AW-1:0] req_idx;
    logic [31:0]   req_wdata;
    logic          req_err;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          range_err;
    logic          align_err;
    logic [3:0]    lane_below;
    logic          acc_we;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;

`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]    req_be;
    logic [3:0]    acc_be;
`else
    logic          unused_byte_en;
    assign unused_byte_en = ^i_ByteEn;
`endif

    // Error classification of the incoming request; upper address bits only feed the range check.
    always_comb begin
        range_err  = |i_Addr[31:AW+2];
        lane_below = (4'b0001 << i_Addr[1:0]) - 4'd1;
        align_err  = |i_Addr[1:0];
`ifdef DMEM_BYTE_WRITE_EN
        if (i_WE) begin
            align_err = |(i_ByteEn & lane_below);
        end
`endif
    end

    // In IDLE the access uses live inputs so a zero-wait request can complete on its accept edge.
    always_comb begin
        accept     = (state == IDLE) && i_Req;
        enter_resp = (accept && (WS == 4'd0)) || ((state == WAIT) && (wait_cnt <= 4'd1));
        acc_we     = (state == IDLE) ? i_WE : req_we;
        acc_err    = (state == IDLE) ? (range_err | align_err) : req_err;
        acc_idx    = (state == IDLE) ? i_Addr[AW+1:2] : req_idx;
        acc_wdata  = (state == IDLE) ? i_WData : req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
        acc_be     = (state == IDLE) ? i_ByteEn : req_be;
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_Req) state_next = (WS == 4'd0) ? RESP : WAIT;
            WAIT: if (wait_cnt <= 4'd1) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_Ready  = (state == IDLE) && i_Reset;
        o_RValid = (state == RESP);
        o_Err    = (state == RESP) && req_err;
        o_RData  = (state == RESP) ? rdata_q : 32'd0;
        o_Busy   = (state != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wait_cnt  <= 4'd0;
            req_we    <= 1'b0;
            req_idx   <= '0;
            req_wdata <= 32'd0;
            req_err   <= 1'b0;
            rdata_q   <= 32'd0;
`ifdef DMEM_BYTE_WRITE_EN
            req_be    <= 4'd0;
`endif
        end else begin
            if (accept) begin
                wait_cnt  <= WS;
                req_we    <= i_WE;
                req_idx   <= i_Addr[AW+1:2];
                req_wdata <= i_WData;
                req_err   <= range_err | align_err;
`ifdef DMEM_BYTE_WRITE_EN
                req_be    <= i_ByteEn;
`endif
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= (!acc_we && !acc_err) ? mem[acc_idx] : 32'd0;
            end
        end
    end

    // Array is deliberately not reset; the reset gate keeps a store from committing while held in reset.
    always_ff @(posedge i_Clk) begin
        if (i_Reset && enter_resp && acc_we && !acc_err) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int lane = 0; lane < 4; lane++) begin
                if (acc_be[lane]) begin
                    mem[acc_idx][8*lane +: 8] <= acc_wdata[8*lane +: 8];
                end
            end
`else
            mem[acc_idx] <= acc_wdata;
`endif
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: three instances with WAIT_STATES of 2, 0 and 3.
// Expected responses are queued at issue time and popped when each response pulse appears.
module tb_data_mem_responder;
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req    [3];
    logic        we     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  be     [3];
    logic        ready  [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];
    logic        busy   [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req[0]), .i_WE(we[0]), .i_Addr(addr[0]),
        .i_WData(wdata[0]), .i_ByteEn(be[0]), .o_Ready(ready[0]), .o_RValid(rvalid[0]),
        .o_RData(rdata[0]), .o_Err(err[0]), .o_Busy(busy[0]));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req[1]), .i_WE(we[1]), .i_Addr(addr[1]),
        .i_WData(wdata[1]), .i_ByteEn(be[1]), .o_Ready(ready[1]), .o_RValid(rvalid[1]),
        .o_RData(rdata[1]), .o_Err(err[1]), .o_Busy(busy[1]));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
        .i_Clk(clk), .i_Reset(rst_n), .i_Req(req[2]), .i_WE(we[2]), .i_Addr(addr[2]),
        .i_WData(wdata[2]), .i_ByteEn(be[2]), .o_Ready(ready[2]), .o_RValid(rvalid[2]),
        .o_RData(rdata[2]), .o_Err(err[2]), .o_Busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and returns just after its accept edge with req dropped.
    task automatic issue(input int idx, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        req[idx] = 1'b1; we[idx] = w; addr[idx] = a; wdata[idx] = d; be[idx] = b;
        for (int n = 0; n < 40; n++) begin
            if (ready[idx] === 1'b1) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req[idx] = 1'b0;
    endtask

    // Latency counts negedge samples after the accept edge; a missing pulse sets timed_out.
    task automatic wait_resp(input int idx, output logic [31:0] d, output logic e,
                             output int lat, output bit timed_out);
        timed_out = 1'b1; lat = 0; d = 'x; e = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            lat++;
            if (rvalid[idx] === 1'b1) begin
                d = rdata[idx]; e = err[idx]; timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low got=%b want=0", ready[0]);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready[0] !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b want=1", ready[0]);
        end
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid got=%b want=0", rvalid[0]);
        end
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", busy[0]);
        end
        checks++;
        if (rdata[0] !== 32'd0 || err[0] !== 1'b0) begin
            errors++; $display("FAIL reset_rdata_err got=%h/%b want=0/0", rdata[0], err[0]);
        end
    endtask

    task automatic test_round_trip();
        logic [31:0] d; logic e; int lat; bit to; exp_t x;
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        sb.push_back('{data: 32'd0, err: 1'b0});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL rt_store_resp got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL rt_store_latency got=%0d want=3", lat);
        end
        @(negedge clk);
        checks++;
        if (rvalid[0] !== 1'b0) begin
            errors++; $display("FAIL rt_single_pulse got=%b want=0", rvalid[0]);
        end
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        sb.push_back('{data: 32'hDEADBEEF, err: 1'b0});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL rt_load_resp got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL rt_load_latency got=%0d want=3", lat);
        end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic e; int lat; bit to; exp_t x;
        issue(0, 1'b1, 32'h0, 32'h11111111, 4'hF);
        sb.push_back('{data: 32'd0, err: 1'b0});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL err_base_store got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
        issue(0, 1'b0, 32'h13, 32'h0, 4'h0);
        sb.push_back('{data: 32'd0, err: 1'b1});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL err_misaligned_load got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
        issue(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
        sb.push_back('{data: 32'd0, err: 1'b1});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL err_range_store got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
        issue(0, 1'b0, 32'h0, 32'h0, 4'h0);
        sb.push_back('{data: 32'h11111111, err: 1'b0});
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL err_no_alias_load got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; int lat; bit to; exp_t x; logic prev_rv; logic exp_rv;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h0BADF00D; be[1] = 4'hF;
        for (int k = 0; k < 4; k++) sb.push_back('{data: 32'd0, err: 1'b0});
        prev_rv = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_rv = (i % 2 == 1);
            checks++;
            if (rvalid[1] !== exp_rv || ready[1] !== !exp_rv) begin
                errors++;
                $display("FAIL b2b_pattern cycle=%0d got rv/rdy=%b/%b want=%b/%b", i, rvalid[1], ready[1], exp_rv, !exp_rv);
            end
            checks++;
            if (prev_rv === 1'b1 && rvalid[1] === 1'b1) begin
                errors++; $display("FAIL b2b_consecutive cycle=%0d got rv=1 twice want single", i);
            end
            if (rvalid[1] === 1'b1 && sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (rdata[1] !== x.data || err[1] !== x.err) begin
                    errors++; $display("FAIL b2b_resp got=%h/%b want=%h/%b", rdata[1], err[1], x.data, x.err);
                end
            end
            prev_rv = rvalid[1];
            if (i == 7) req[1] = 1'b0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL b2b_count got pending=%0d want=0", sb.size());
            sb.delete();
        end
        issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
        sb.push_back('{data: 32'h0BADF00D, err: 1'b0});
        wait_resp(1, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err || lat != 1) begin
            errors++; $display("FAIL b2b_load got=%h/%b lat=%0d want=%h/%b lat=1", d, e, lat, x.data, x.err);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] d; logic e; int lat; bit to; exp_t x;
        issue(2, 1'b1, 32'h20, 32'h55AA55AA, 4'hF);
        wait_resp(2, d, e, lat, to);
        checks++;
        if (to || e !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL mid_prior_store got err=%b lat=%0d to=%0d want err=0 lat=4", e, lat, to);
        end
        issue(2, 1'b1, 32'h20, 32'h12345678, 4'hF);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || rvalid[2] !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle got busy/rv=%b/%b want=0/0", busy[2], rvalid[2]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
        sb.push_back('{data: 32'h55AA55AA, err: 1'b0});
        wait_resp(2, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL mid_reset_load got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] d; logic e; int lat; bit to; exp_t x;
        issue(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
        wait_resp(0, d, e, lat, to);
        issue(0, 1'b1, 32'h8, 32'h000000EE, 4'b0001);
        wait_resp(0, d, e, lat, to);
        issue(0, 1'b0, 32'h8, 32'h0, 4'h0);
`ifdef DMEM_BYTE_WRITE_EN
        sb.push_back('{data: 32'hAABBCCEE, err: 1'b0});
`else
        sb.push_back('{data: 32'h000000EE, err: 1'b0});
`endif
        wait_resp(0, d, e, lat, to);
        x = sb.pop_front();
        checks++;
        if (to || d !== x.data || e !== x.err) begin
            errors++; $display("FAIL byte_write_load got=%h/%b to=%0d want=%h/%b", d, e, to, x.data, x.err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; be[k] = 4'd0;
        end
        test_reset();
        test_round_trip();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        test_byte_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined core's data port. It accepts one load/store request at a time through a req/ready handshake, inserts a programmable number of wait states, performs the access on an internal word array, and returns a single-cycle response pulse carrying read data or an error flag. It sits behind the core's Memory stage and drives the stall/response path that the hazard logic consumes.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array; power of two, ≥4.
- `WAIT_STATES`, default 2: cycles spent in WAIT before responding; 0–15 legal.

- `i_Clk`, in, 1: clock; all state on rising edge.
- `i_Reset`, in, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `i_Req`, in, 1: request valid.
- `i_WE`, in, 1: 1 = store, 0 = load; sampled with `i_Req`.
- `i_Addr`, in, 32: byte address.
- `i_WData`, in, 32: store data.
- `i_ByteEn`, in, 4: store byte lanes, bit n → bits [8n+7:8n].
- `o_Ready`, out, 1: request accepted this cycle when `i_Req & o_Ready`.
- `o_RValid`, out, 1: one-cycle response pulse.
- `o_RData`, out, 32: load data, valid only with `o_RValid`; 0 for stores and errors.
- `o_Err`, out, 1: qualifies `o_RValid`; access was misaligned or out of range.
- `o_Busy`, out, 1: request in flight (state ≠ IDLE).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `o_Ready` = 1. On `i_Req` = 1, capture `i_WE`, `i_Addr`, `i_WData`, `i_ByteEn` into request registers. Compute the error flag = (`i_Addr[1:0]` ≠ 0) | (`i_Addr` ≥ 4·DEPTH_WORDS). Load the wait counter with WAIT_STATES. Go to WAIT, or to RESP if WAIT_STATES = 0.
- WAIT: decrement the counter. When it reaches 1, go to RESP; total WAIT_STATES cycles. Inputs are ignored.
- RESP: `o_RValid` = 1 for exactly this cycle, and `o_Err` = captured flag. Return to IDLE next edge.
  - Load, no error: `o_RData` = mem[addr[log2(DEPTH_WORDS)+1:2]], registered on WAIT→RESP entry.
  - Store, no error: write commits on the edge entering RESP; `o_RData` = 0.
  - Error: no array access; `o_RData` = 0.
- `o_Ready` = 0 in WAIT and RESP. The earliest next accept is the cycle after RESP.
- Array contents are not reset. Reads of never-written words return X in simulation.
- Address index uses `i_Addr[log2(DEPTH_WORDS)+1:2]`. Upper bits only feed the range check; there is no wrap-around aliasing.

## Timing
- Reset values: state = IDLE, `o_Ready` = 1 after release (0 while `i_Reset` = 0), `o_RValid` = 0, `o_RData` = 0, `o_Err` = 0, `o_Busy` = 0, counter = 0.
- Latency: with accept at edge T, `o_RValid` is high in cycle T+WAIT_STATES+1 (relative to the accept edge).
- Throughput: one request per WAIT_STATES+2 cycles.
- `o_Ready` is combinational from state only. It does not depend on `i_Req`.
- Reset asserted mid-operation: FSM returns to IDLE immediately and `o_RValid` drops.
  - A store that has not yet reached the RESP-entry edge is not committed.
  - A store already committed stays written.
- `i_Req` held high across RESP: the request is re-accepted in the following IDLE cycle as a new request. The requester must deassert after acceptance.

## Configuration
- `DMEM_BYTE_WRITE_EN` defined: stores honour `i_ByteEn`, and only enabled lanes are written.
  - Misalignment check relaxes to: error if the enabled lanes fall outside the addressed word.
  - In practice, `i_Addr[1:0]` ≠ 0 is legal when `i_ByteEn` is zero below lane `i_Addr[1:0]`.
  - Loads stay word-only, aligned.
- Not defined: `i_ByteEn` is ignored. Every non-error store writes all 32 bits, and any `i_Addr[1:0]` ≠ 0 is an error.

## Test plan
- Reset then idle: hold `i_Reset` = 0 for 3 cycles, release → `o_Ready` = 1, `o_RValid` = 0, `o_Busy` = 0.
- Store/load round trip, WAIT_STATES = 2: store 0xDEADBEEF to 0x10, then load 0x10.
  - `o_RValid` is high exactly 3 cycles after each accept edge.
  - The load returns 0xDEADBEEF with `o_Err` = 0.
- Error cases:
  - Load 0x13 → `o_RValid` = 1, `o_Err` = 1, `o_RData` = 0.
  - Store to 0x400 (DEPTH_WORDS = 256) → `o_Err` = 1, and a later load of 0x0 is unchanged.
- WAIT_STATES = 0 and back-to-back: hold `i_Req` = 1 for 4 requests → accepts every 2nd cycle; `o_RValid` pulses every 2nd cycle and never for two consecutive cycles.
- Reset mid-store: accept a store of 0x12345678 to 0x20 (WAIT_STATES = 3), assert `i_Reset` = 0 in WAIT cycle 1 → after release, a load of 0x20 returns the prior value.
- With `DMEM_BYTE_WRITE_EN`: word 0x8 = 0xAABBCCDD, then store 0x000000EE, `i_ByteEn` = 0001 → load returns 0xAABBCCEE. Without the macro, the same load returns 0x000000EE.
